// File: rtl/tft_frame_streamer.sv
// Frame word generator feeding the TFT SPI serializer: window setup commands,
// RAM-write command, then WIDTH*HEIGHT RGB565 pixels over a valid/ready stream.
module tft_frame_streamer #(
  parameter int          WIDTH     = 320,
  parameter int          HEIGHT    = 240,
  parameter int          X0        = 0,
  parameter int          Y0        = 0,
  parameter logic [15:0] CMD_CASET = 16'h002A,
  parameter logic [15:0] CMD_RASET = 16'h002B,
  parameter logic [15:0] CMD_RAMWR = 16'h002C
) (
  input  logic        MasterCLK,
  input  logic        RST,
  input  logic        init_done,
  input  logic        frame_start,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [15:0] word_data,
  output logic        word_rs,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        busy,
  output logic        line_done,
  output logic        frame_done
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_CASET_C, ST_CASET_A, ST_CASET_B, ST_RASET_C,
    ST_RASET_A, ST_RASET_B, ST_RAMWR_C, ST_PIXELS, ST_DONE
  } state_t;

  localparam logic [15:0] X_START  = 16'(X0);
  localparam logic [15:0] X_END    = 16'(X0 + WIDTH - 1);
  localparam logic [15:0] Y_START  = 16'(Y0);
  localparam logic [15:0] Y_END    = 16'(Y0 + HEIGHT - 1);
  localparam logic [11:0] COL_LAST = 12'(WIDTH - 1);
  localparam logic [11:0] ROW_LAST = 12'(HEIGHT - 1);

  state_t      state_q, state_d;
  logic [15:0] word_data_q, word_data_d;
  logic        word_rs_q, word_rs_d;
  logic        word_valid_q, word_valid_d;
  logic        tag_line_q, tag_line_d;
  logic        tag_frame_q, tag_frame_d;
  logic        busy_q, busy_d;
  logic        line_done_q, line_done_d;
  logic        frame_done_q, frame_done_d;
  logic [11:0] col_q, col_d;
  logic [11:0] row_q, row_d;

  logic load_ok_s;
  logic beat_s;
  logic pix_xfer_s;

  assign load_ok_s  = !word_valid_q || word_ready;
  assign beat_s     = word_valid_q && word_ready;
  assign pix_xfer_s = (state_q == ST_PIXELS) && pix_valid && load_ok_s;

  // Next-state, output-register and pixel-counter logic
  always_comb begin
    state_d      = state_q;
    word_data_d  = word_data_q;
    word_rs_d    = word_rs_q;
    word_valid_d = word_valid_q;
    tag_line_d   = tag_line_q;
    tag_frame_d  = tag_frame_q;
    busy_d       = busy_q;
    col_d        = col_q;
    row_d        = row_q;
    line_done_d  = beat_s && tag_line_q;
    frame_done_d = beat_s && tag_frame_q;

    if (beat_s) begin
      word_valid_d = 1'b0;
      tag_line_d   = 1'b0;
      tag_frame_d  = 1'b0;
    end else begin
      word_valid_d = word_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        // A start coinciding with the previous frame's done pulse is dropped
        if (frame_start && init_done && !frame_done_q) begin
          state_d = ST_CASET_C;
          busy_d  = 1'b1;
          col_d   = 12'd0;
          row_d   = 12'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CASET_C, ST_CASET_A, ST_CASET_B,
      ST_RASET_C, ST_RASET_A, ST_RASET_B, ST_RAMWR_C: begin
        if (load_ok_s) begin
          word_valid_d = 1'b1;
          tag_line_d   = 1'b0;
          tag_frame_d  = 1'b0;
          case (state_q)
            ST_CASET_C: begin word_data_d = CMD_CASET; word_rs_d = 1'b0; state_d = ST_CASET_A; end
            ST_CASET_A: begin word_data_d = X_START;   word_rs_d = 1'b1; state_d = ST_CASET_B; end
            ST_CASET_B: begin word_data_d = X_END;     word_rs_d = 1'b1; state_d = ST_RASET_C; end
            ST_RASET_C: begin word_data_d = CMD_RASET; word_rs_d = 1'b0; state_d = ST_RASET_A; end
            ST_RASET_A: begin word_data_d = Y_START;   word_rs_d = 1'b1; state_d = ST_RASET_B; end
            ST_RASET_B: begin word_data_d = Y_END;     word_rs_d = 1'b1; state_d = ST_RAMWR_C; end
            default:    begin word_data_d = CMD_RAMWR; word_rs_d = 1'b0; state_d = ST_PIXELS;  end
          endcase
        end else begin
          state_d = state_q;
        end
      end
      ST_PIXELS: begin
        if (pix_xfer_s) begin
          word_data_d  = pix_data;
          word_rs_d    = 1'b1;
          word_valid_d = 1'b1;
          tag_line_d   = (col_q == COL_LAST);
          tag_frame_d  = (col_q == COL_LAST) && (row_q == ROW_LAST);
          if (col_q == COL_LAST) begin
            col_d = 12'd0;
            if (row_q == ROW_LAST) begin
              row_d   = 12'd0;
              state_d = ST_DONE;
            end else begin
              row_d = row_q + 12'd1;
            end
          end else begin
            col_d = col_q + 12'd1;
          end
        end else begin
          state_d = ST_PIXELS;
        end
      end
      ST_DONE: begin
        if (beat_s && tag_frame_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge MasterCLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      word_data_q  <= 16'd0;
      word_rs_q    <= 1'b0;
      word_valid_q <= 1'b0;
      tag_line_q   <= 1'b0;
      tag_frame_q  <= 1'b0;
      busy_q       <= 1'b0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      col_q        <= 12'd0;
      row_q        <= 12'd0;
    end else begin
      state_q      <= state_d;
      word_data_q  <= word_data_d;
      word_rs_q    <= word_rs_d;
      word_valid_q <= word_valid_d;
      tag_line_q   <= tag_line_d;
      tag_frame_q  <= tag_frame_d;
      busy_q       <= busy_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      col_q        <= col_d;
      row_q        <= row_d;
    end
  end

  // Pixel acceptance follows output-register space combinationally
  assign pix_ready  = (state_q == ST_PIXELS) && load_ok_s;
  assign word_data  = word_data_q;
  assign word_rs    = word_rs_q;
  assign word_valid = word_valid_q;
  assign busy       = busy_q;
  assign line_done  = line_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tft_frame_streamer.sv
// Self-checking bench for tft_frame_streamer: directed and randomized frames
// compared against a word-queue reference model.
module tb_tft_frame_streamer;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done, frame_start, pix_valid, word_ready;
  logic [15:0] pix_data;
  logic        pix_ready, word_rs, word_valid, busy, line_done, frame_done;
  logic [15:0] word_data;

  tft_frame_streamer #(.WIDTH(W), .HEIGHT(H), .X0(2), .Y0(5)) dut (
    .MasterCLK(clk), .RST(rst_n), .init_done(init_done), .frame_start(frame_start),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .word_data(word_data), .word_rs(word_rs), .word_valid(word_valid),
    .word_ready(word_ready), .busy(busy), .line_done(line_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state
  logic [16:0] expq[$];
  logic        model_busy, exp_ld, exp_fd;
  int          cmd_beats, pix_in, pix_out, start_age, start_cyc, fd_cyc;
  logic        seen_fd;
  logic        prev_hold, prev_valid, prev_beat, prev_xfer, prev_cmd_done;
  logic [16:0] prev_word, prev_pix;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic reset_model();
    expq.delete();
    model_busy = 1'b0; exp_ld = 1'b0; exp_fd = 1'b0;
    cmd_beats = 0; pix_in = 0; pix_out = 0; start_age = -1;
    prev_hold = 1'b0; prev_valid = 1'b0; prev_beat = 1'b0; prev_xfer = 1'b0;
    prev_cmd_done = 1'b0; prev_word = 17'd0; prev_pix = 17'd0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_word_data"}, 32'(word_data), 32'd0);
    chk({tag, "_word_rs"}, 32'(word_rs), 32'd0);
    chk({tag, "_word_valid"}, 32'(word_valid), 32'd0);
    chk({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_line_done"}, 32'(line_done), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  // One clock: sample and check at the falling edge, then advance the model
  task automatic step();
    logic beat, xfer, nxt_ld, nxt_fd, end_frame;
    logic [31:0] exp_w;
    @(negedge clk);
    cyc++;
    beat = word_valid && word_ready;
    xfer = pix_valid && pix_ready;

    chk("line_done", 32'(line_done), 32'(exp_ld));
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    chk("busy", 32'(busy), 32'(model_busy));
    if (frame_done) begin seen_fd = 1'b1; fd_cyc = cyc; end
    if (!model_busy) begin
      chk("idle_valid", 32'(word_valid), 32'd0);
      chk("idle_pix_ready", 32'(pix_ready), 32'd0);
    end
    if (prev_hold) chk("hold_word", {15'd0, word_valid, word_rs, word_data}, {15'd0, 1'b1, prev_word});
    if (start_age == 2) chk("first_word_latency", 32'(word_valid), 32'd1);
    if (prev_xfer) chk("pix_to_word", {15'd0, word_valid, word_rs, word_data}, {15'd0, 1'b1, prev_pix});
    if (model_busy && prev_cmd_done && !prev_xfer && (!prev_valid || prev_beat))
      chk("bubble", 32'(word_valid), 32'd0);
    if (word_valid && !word_ready) chk("pix_ready_full", 32'(pix_ready), 32'd0);
    else if (model_busy && cmd_beats >= 7 && pix_in < NPIX) chk("pix_ready_open", 32'(pix_ready), 32'd1);
    if (model_busy && (cmd_beats < 6 || pix_in >= NPIX)) chk("pix_ready_closed", 32'(pix_ready), 32'd0);

    nxt_ld = 1'b0; nxt_fd = 1'b0; end_frame = 1'b0;
    if (beat) begin
      exp_w = (expq.size() != 0) ? {15'd0, expq[0]} : 32'hDEADBEEF;
      chk("word", {15'd0, word_rs, word_data}, exp_w);
      if (expq.size() != 0) void'(expq.pop_front());
      if (cmd_beats < 7) cmd_beats++;
      else begin
        pix_out++;
        if (pix_out % W == 0) nxt_ld = 1'b1;
        if (pix_out == NPIX) begin nxt_fd = 1'b1; end_frame = 1'b1; end
      end
    end
    if (xfer) begin
      expq.push_back({1'b1, pix_data});
      pix_in++;
    end
    prev_hold = word_valid && !word_ready;
    prev_word = {word_rs, word_data};
    prev_valid = word_valid;
    prev_beat = beat;
    prev_xfer = xfer;
    prev_pix = {1'b1, pix_data};
    if (start_age >= 0) start_age++;
    if (frame_start && init_done && !model_busy && !exp_fd) begin
      model_busy = 1'b1;
      expq.delete();
      expq.push_back({1'b0, 16'h002A}); expq.push_back({1'b1, 16'd2}); expq.push_back({1'b1, 16'd5});
      expq.push_back({1'b0, 16'h002B}); expq.push_back({1'b1, 16'd5}); expq.push_back({1'b1, 16'd6});
      expq.push_back({1'b0, 16'h002C});
      cmd_beats = 0; pix_in = 0; pix_out = 0; start_age = 0; start_cyc = cyc;
    end
    if (end_frame) begin model_busy = 1'b0; start_age = -1; end
    prev_cmd_done = (cmd_beats == 7);
    exp_ld = nxt_ld;
    exp_fd = nxt_fd;
    @(posedge clk);
    #1;
  endtask

  // mode: 0 full rate, 1 backpressure, 2 underflow, 3 random, 4 second start,
  // 5 start during frame_done, 6 stop at pixel 5 (for mid-frame reset)
  task automatic run_frame(input int mode);
    int gap = 0;
    logic sec_sent = 1'b0;
    logic gap_done = 1'b0;
    seen_fd = 1'b0;
    for (int k = 0; k < 300 && !seen_fd; k++) begin
      if (mode == 6 && pix_in >= 5) break;
      pix_data    = 16'($urandom);
      word_ready  = 1'b1;
      pix_valid   = 1'b1;
      frame_start = (k == 0);
      if (mode == 1 && ((k >= 3 && k <= 7) || (k >= 13 && k <= 17))) word_ready = 1'b0;
      if (mode == 2) begin
        if (pix_in == 2 && !gap_done) begin gap = 3; gap_done = 1'b1; end
        if (gap > 0) begin pix_valid = 1'b0; gap--; end
      end
      if (mode == 3) begin
        word_ready = ($urandom_range(0, 3) != 0);
        pix_valid  = ($urandom_range(0, 3) != 0);
      end
      if (mode == 4 && pix_in == 3 && !sec_sent) begin frame_start = 1'b1; sec_sent = 1'b1; end
      if (mode == 5 && exp_fd) frame_start = 1'b1;
      step();
    end
    frame_start = 1'b0;
    if (mode != 6) begin
      chk("frame_completed", 32'(seen_fd), 32'd1);
      if (mode == 0 && seen_fd) chk("frame_cycles", 32'(fd_cyc - start_cyc), 32'd17);
      for (int i = 0; i < 4; i++) step();
    end
  endtask

  initial begin
    rst_n = 1'b0; init_done = 1'b0; frame_start = 1'b0;
    pix_valid = 1'b0; word_ready = 1'b0; pix_data = 16'd0;
    reset_model();
    seen_fd = 1'b0; start_cyc = 0; fd_cyc = 0;
    #3;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // Start request without panel initialisation is dropped
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < 4; i++) step();

    init_done = 1'b1;
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(4);
    run_frame(5);
    run_frame(3);
    run_frame(3);

    // Mid-frame asynchronous reset, then a clean frame
    run_frame(6);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    reset_model();
    step();
    step();
    rst_n = 1'b1;
    step();
    run_frame(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tft_frame_streamer.md
Name: tft_frame_streamer

Overview:
- Stage directly upstream of the TFT SPI serializer.
- After panel initialisation completes, each frame it emits a window-setup command sequence, then a RAM-write command, then WIDTH*HEIGHT RGB565 pixel words taken from a pixel source.
- Output is a 16-bit word stream with an RS (command/data) flag and a valid/ready handshake; the serializer consumes one word per accepted beat.

Parameters:
- WIDTH, 320, active window width in pixels (1..4095)
- HEIGHT, 240, active window height in lines (1..4095)
- X0, 0, first column address
- Y0, 0, first row address
- CMD_CASET, 16'h002A, column-address command word
- CMD_RASET, 16'h002B, row-address command word
- CMD_RAMWR, 16'h002C, memory-write command word

Ports:
- MasterCLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- init_done  in  1  panel initialisation finished; level, may rise at any time
- frame_start  in  1  single-cycle request to begin a frame
- pix_data  in  16  RGB565 pixel from source
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  streamer accepts pix_data this cycle
- word_data  out  16  word to serializer
- word_rs  out  1  0 = command, 1 = data/parameter
- word_valid  out  1  word_data/word_rs valid
- word_ready  in  1  serializer accepts word this cycle
- busy  out  1  frame in progress
- line_done  out  1  one-cycle pulse after last pixel of each line is accepted downstream
- frame_done  out  1  one-cycle pulse after last pixel of frame is accepted downstream

Behaviour:
- Reset (RST=0, async):
  - state=IDLE; word_data=0, word_rs=0, word_valid=0; pix_ready=0; busy=0; line_done=0; frame_done=0; column/row counters = 0.
- Handshake:
  - A beat occurs when word_valid && word_ready.
  - While word_valid=1 and word_ready=0, word_data and word_rs hold stable.
  - word_valid never drops without a beat.
- Output register: single stage. The register loads only when empty (word_valid=0) or being emptied this cycle (beat).
- State machine: IDLE, CASET_C, CASET_A, CASET_B, RASET_C, RASET_A, RASET_B, RAMWR_C, PIXELS, DONE.
- Command sequence:
  - IDLE: frame_start && init_done -> CASET_C and busy=1 next cycle. frame_start while init_done=0 is dropped.
  - CASET_C loads {CMD_CASET, rs=0}, then CASET_A loads {X0, rs=1}, then CASET_B loads {X0+WIDTH-1, rs=1}.
  - RASET_C / RASET_A / RASET_B do the same with CMD_RASET, Y0, Y0+HEIGHT-1.
  - RAMWR_C loads {CMD_RAMWR, rs=0}.
  - Each state advances only when its word is loaded into the output register.
  - Arithmetic is 16-bit unsigned; upper bits are zero.
- PIXELS:
  - pix_ready = (!word_valid || word_ready).
  - A pixel transfer occurs when pix_valid && pix_ready; it loads {pix_data, rs=1} and increments col.
  - At col==WIDTH-1: col wraps to 0 and row increments.
  - After the last pixel (col==WIDTH-1, row==HEIGHT-1) is loaded -> DONE; pix_ready=0 outside PIXELS.
- Source underflow: if pix_valid=0 and the output register empties, word_valid=0 (bubble). No filler words are inserted.
- line_done / frame_done:
  - line_done pulses the cycle after the beat carrying the last pixel of a line.
  - frame_done pulses together with the final line_done, then state=IDLE and busy=0.
  - Tracking uses a one-bit "last-of-line/last-of-frame" tag stored alongside the output register.
- Simultaneous events:
  - frame_start while busy=1 is ignored.
  - frame_start in the same cycle as frame_done is ignored; a new frame requires a later pulse.
  - A frame_start that arrives while busy=1 is not queued.
- init_done falling mid-frame does not abort; the frame completes.
- Reset mid-frame returns immediately to reset values; the partially sent frame is abandoned.
- Latency:
  - frame_start to first word_valid = 2 cycles (state entry, then register load).
  - A pixel accepted on cycle n appears on word_data at cycle n+1.
  - With word_ready and pix_valid held 1, one word is sent per cycle.

Test Plan:
- WIDTH=4, HEIGHT=2, X0=2, Y0=5; init_done=1; frame_start pulse; word_ready=1 and pix_valid=1 constant.
  - Expect words 002A(rs0), 0002, 0005, 002B(rs0), 0005, 0006, 002C(rs0), then 8 pixel words in source order (rs1), one per cycle.
  - Expect line_done after pixel 4 and pixel 8, frame_done with the second line_done, busy=0 afterwards.
- Backpressure:
  - Hold word_ready=0 for 5 cycles during CASET_A and again mid-pixels.
  - Expect word_data/word_rs stable, pix_ready=0 while the register is full, no word lost or duplicated; sequence identical to the first scenario.
- Underflow: drop pix_valid for 3 cycles after pixel 2 -> word_valid=0 for the gap, resumes with pixel 3; frame_done still after exactly 8 pixel beats.
- frame_start with init_done=0 -> stays IDLE, no word_valid; then raise init_done and pulse again -> normal frame.
- A second frame_start at pixel 3 is ignored (only 8 pixels accepted, one frame_done).
- Assert RST low at pixel 5 -> all outputs go to reset values asynchronously; after release, a new frame_start gives the full sequence from 002A.
